// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-timer random delay generator.
// Holds the FSM state enum, default parameter values and the LFSR tap positions.
package reaction_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int              LFSR_W_DEF = 10;
  localparam int              MIN_MS_DEF = 1000;
  localparam int              DLY_W_DEF  = 13;
  localparam logic [9:0]      SEED_DEF   = 10'h001;

  // Fibonacci taps for x^10 + x^7 + 1
  localparam int              TAP_HI     = 9;
  localparam int              TAP_LO     = 6;

endpackage

// File: rtl/lfsr_step.sv
// Free-running Fibonacci LFSR, stepping every clock out of reset.
// Synchronous reset loads SEED; a stuck all-zero state reloads SEED on the next clock.
module lfsr_step
  import reaction_pkg::*;
#(
  parameter int             W     = LFSR_W_DEF,
  parameter logic [W-1:0]   SEED  = W'(SEED_DEF),
  parameter int             TAP_A = TAP_HI,
  parameter int             TAP_B = TAP_LO
) (
  input  logic         MAX10_CLK1_50,
  input  logic         reset,
  output logic [W-1:0] lfsr
);

  logic [W-1:0] lfsr_next;

  always_comb begin
    lfsr_next = {lfsr[W-2:0], lfsr[TAP_A] ^ lfsr[TAP_B]};
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (lfsr == '0) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/reaction_delay_gen.sv
// Random-delay generator: on start, waits MIN_MS + lfsr ticks of tick_1khz, then pulses delay_ready.
// Define REACTION_DELAY_FALSE_START_EN to turn an early key_press into a false_start pulse.
//
// Handshake: start/abort/key_press/tick_1khz are single-cycle strobes sampled on the clock
// edge; there is no back-pressure. start is accepted only while busy is low.
module reaction_delay_gen
  import reaction_pkg::*;
#(
  parameter int                  LFSR_W = LFSR_W_DEF,
  parameter int                  MIN_MS = MIN_MS_DEF,
  parameter logic [LFSR_W-1:0]   SEED   = LFSR_W'(SEED_DEF),
  parameter int                  DLY_W  = DLY_W_DEF
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset,
  input  logic             tick_1khz,
  input  logic             start,
  input  logic             abort,
  input  logic             key_press,
  output logic             busy,
  output logic             delay_ready,
  output logic             false_start,
  output logic [DLY_W-1:0] delay_ms
);

  state_t             state_q, state_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic               ready_q, ready_d;
  logic [LFSR_W-1:0]  lfsr;
  logic [DLY_W-1:0]   start_val;

`ifdef REACTION_DELAY_FALSE_START_EN
  logic               fs_q, fs_d;
`else
  logic               unused_key_press;
  assign unused_key_press = key_press;
`endif

  lfsr_step #(
    .W     (LFSR_W),
    .SEED  (SEED),
    .TAP_A (TAP_HI),
    .TAP_B (TAP_LO)
  ) u_lfsr (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .reset         (reset),
    .lfsr          (lfsr)
  );

  // Current (pre-step) LFSR value, zero-extended, on top of the fixed minimum.
  assign start_val = DLY_W'(MIN_MS) + {{(DLY_W-LFSR_W){1'b0}}, lfsr};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    ready_d = 1'b0;
`ifdef REACTION_DELAY_FALSE_START_EN
    fs_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          delay_d = start_val;
          cnt_d   = start_val;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Priority: abort, then early press, then the tick.
        if (abort) begin
          state_d = IDLE;
`ifdef REACTION_DELAY_FALSE_START_EN
        end else if (key_press) begin
          state_d = IDLE;
          fs_d    = 1'b1;
`endif
        end else if (tick_1khz) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DLY_W'(1)) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      ready_q <= 1'b0;
`ifdef REACTION_DELAY_FALSE_START_EN
      fs_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      ready_q <= ready_d;
`ifdef REACTION_DELAY_FALSE_START_EN
      fs_q    <= fs_d;
`endif
    end
  end

  assign busy        = (state_q == COUNT);
  assign delay_ready = ready_q;
  assign delay_ms    = delay_q;
`ifdef REACTION_DELAY_FALSE_START_EN
  assign false_start = fs_q;
`else
  assign false_start = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_delay_gen.sv
// Directed-plus-random bench for reaction_delay_gen against an integer behavioural model.
// Honours REACTION_DELAY_FALSE_START_EN the same way the design does.
module tb_reaction_delay_gen;

  localparam int DLY_W  = 13;
  localparam int MIN_MS = 1000;
`ifdef REACTION_DELAY_FALSE_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  // clock / reset block
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick_1khz = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             key_press = 1'b0;
  logic             busy;
  logic             delay_ready;
  logic             false_start;
  logic [DLY_W-1:0] delay_ms;

  always #10 clk = ~clk;

  reaction_delay_gen dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .tick_1khz     (tick_1khz),
    .start         (start),
    .abort         (abort),
    .key_press     (key_press),
    .busy          (busy),
    .delay_ready   (delay_ready),
    .false_start   (false_start),
    .delay_ms      (delay_ms)
  );

  // reference model state
  logic [9:0]  m_lfsr = 10'h001;
  bit          m_busy = 1'b0;
  int          m_rem = 0;
  int          m_delay = 0;
  int          n_ticks = 0;
  int          n_ready = 0;
  int          n_fs = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic rt();
    return ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
  endfunction

  // driver: one clock with the given inputs, then model update and output checks
  task automatic step(input logic r, input logic s, input logic a, input logic t, input logic k);
    bit exp_ready;
    bit exp_fs;
    reset = r; start = s; abort = a; tick_1khz = t; key_press = k;
    @(posedge clk);
    exp_ready = 1'b0;
    exp_fs    = 1'b0;
    if (r) begin
      m_busy  = 1'b0;
      m_delay = 0;
      m_lfsr  = 10'h001;
    end else begin
      if (!m_busy) begin
        if (s && !a) begin
          m_delay = MIN_MS + int'(m_lfsr);
          m_rem   = m_delay;
          m_busy  = 1'b1;
          n_ticks = 0;
        end
      end else if (a) begin
        m_busy = 1'b0;
      end else if (FS_EN && k) begin
        m_busy = 1'b0;
        exp_fs = 1'b1;
      end else if (t) begin
        n_ticks++;
        m_rem--;
        if (m_rem == 0) begin
          m_busy    = 1'b0;
          exp_ready = 1'b1;
        end
      end
      m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
    #1;
    chk("busy", busy, m_busy);
    chk("delay_ready", delay_ready, exp_ready);
    chk("false_start", false_start, exp_fs);
    chk("delay_ms", delay_ms, m_delay);
    if (delay_ready) n_ready++;
    if (false_start) n_fs++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, rt(), 1'b0);
  endtask

  // tick until target counted ticks or the model leaves COUNT, with a cycle bound
  task automatic run_ticks(input int target);
    int g;
    g = 0;
    while (m_busy && n_ticks < target && g < 20000) begin
      step(1'b0, 1'b0, 1'b0, rt(), 1'b0);
      g++;
    end
    if (g >= 20000) chk("timeout", 1, 0);
  endtask

  task automatic run_done();
    run_ticks(32'h7fff_ffff);
  endtask

  initial begin
    int r0;
    int f0;
    int saved;

    // 1: reset then immediate start
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_delay_ms", delay_ms, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("first_delay", delay_ms, 1001);
    r0 = n_ready;
    run_done();
    chk("t1_ticks", n_ticks, 1001);
    chk("t1_ready_cnt", n_ready - r0, 1);
    // restart in the delay_ready cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy", busy, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: abort mid-count
    idle($urandom_range(1, 9));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(500);
    r0 = n_ready;
    step(1'b0, 1'b0, 1'b1, rt(), 1'b0);
    chk("abort_busy", busy, 0);
    idle(40);
    chk("abort_no_ready", n_ready - r0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    r0 = n_ready;
    run_done();
    chk("t2_ready_cnt", n_ready - r0, 1);

    // 3: abort on the final tick, then start+abort in IDLE
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(m_delay - 1);
    r0 = n_ready;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_final_ready", n_ready - r0, 0);
    saved = m_delay;
    idle(3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_delay", delay_ms, saved);

    // 4: start during COUNT is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    saved = m_delay;
    run_ticks(10);
    step(1'b0, 1'b1, 1'b0, rt(), 1'b0);
    chk("rearm_delay", delay_ms, saved);
    r0 = n_ready;
    run_done();
    chk("rearm_ticks", n_ticks, saved);
    chk("rearm_ready_cnt", n_ready - r0, 1);

    // 5: reset mid-count
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(700);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_lfsr", dut.u_lfsr.lfsr, 10'h001);
    r0 = n_ready;
    repeat (2500) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_no_late_ready", n_ready - r0, 0);

    // 6: key press at tick 300
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_ticks(300);
    r0 = n_ready;
    f0 = n_fs;
    step(1'b0, 1'b0, 1'b0, rt(), 1'b1);
    run_done();
    chk("fs_ready_cnt", n_ready - r0, FS_EN ? 0 : 1);
    chk("fs_pulses", n_fs - f0, FS_EN ? 1 : 0);

    // 7: random sessions with occasional abort / key press
    repeat (3) begin
      int g;
      idle($urandom_range(0, 20));
      step(1'b0, 1'b1, $urandom_range(0, 7) == 0, rt(), 1'b0);
      g = 0;
      while (m_busy && g < 20000) begin
        step(1'b0, $urandom_range(0, 50) == 0, $urandom_range(0, 4000) == 0,
             rt(), $urandom_range(0, 4000) == 0);
        g++;
      end
      if (g >= 20000) chk("timeout", 1, 0);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
